// File: rtl/tt_um_uwasic_onboarding_jonathan.sv
// tt_um_uwasic_onboarding_jonathan
// Tiny Tapeout user top: SPI write-only register file (5 x 8-bit) driving a
// 16-channel PWM / static output stage. Channels 0-7 on uo_out, 8-15 on uio_out.
// Optional macro ENA_GATE_EN: when defined, ena=0 forces all outputs low while
// the register file keeps accepting SPI writes.
module tt_um_uwasic_onboarding_jonathan #(
  parameter int unsigned PWM_DIV     = 13,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PWM_DIV - 1);

  // ---------------------------------------------------------------------------
  // SPI input synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_copi_sync;
  logic [SYNC_STAGES-1:0] r_ncs_sync;
  logic                   r_sclk_d;
  logic                   r_ncs_d;

  logic w_sclk;
  logic w_copi;
  logic w_ncs;
  logic w_sclk_rise;
  logic w_ncs_fall;
  logic w_ncs_rise;

  // Multi-stage synchronisers; nCS idles high so reset does not fake a frame start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_copi_sync <= '0;
      r_ncs_sync  <= '1;
    end else begin
      r_sclk_sync[0] <= ui_in[0];
      r_copi_sync[0] <= ui_in[1];
      r_ncs_sync[0]  <= ui_in[2];
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        r_sclk_sync[k] <= r_sclk_sync[k-1];
        r_copi_sync[k] <= r_copi_sync[k-1];
        r_ncs_sync[k]  <= r_ncs_sync[k-1];
      end
    end
  end

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_copi = r_copi_sync[SYNC_STAGES-1];
  assign w_ncs  = r_ncs_sync[SYNC_STAGES-1];

  // Previous synchronised levels for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sclk_d <= 1'b0;
      r_ncs_d  <= 1'b1;
    end else begin
      r_sclk_d <= w_sclk;
      r_ncs_d  <= w_ncs;
    end
  end

  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_ncs_fall  = ~w_ncs & r_ncs_d;
  assign w_ncs_rise  = w_ncs & ~r_ncs_d;

  // ---------------------------------------------------------------------------
  // Frame shifter: R/W bit, 7-bit address, 8-bit data, MSB first
  // ---------------------------------------------------------------------------
  logic [15:0] r_shift;
  logic [4:0]  r_bitcnt;
  logic        w_frame_full;
  logic        w_commit;
  logic [6:0]  w_addr;
  logic [7:0]  w_data;

  assign w_frame_full = (r_bitcnt == 5'd16);

  // Shift COPI on each SCLK rise while selected; the count saturates at 16.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
    end else if (w_ncs_fall) begin
      r_bitcnt <= '0;
    end else if (!w_ncs && w_sclk_rise && !w_frame_full) begin
      r_shift  <= {r_shift[14:0], w_copi};
      r_bitcnt <= r_bitcnt + 5'd1;
    end
  end

  assign w_addr   = r_shift[14:8];
  assign w_data   = r_shift[7:0];
  assign w_commit = w_ncs_rise && w_frame_full && r_shift[15] && (w_addr <= 7'd4);

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  logic [15:0] r_en_out;
  logic [15:0] r_en_pwm;
  logic [7:0]  r_duty;

  // Commit a complete, in-range write frame on the synchronised nCS rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_en_out <= '0;
      r_en_pwm <= '0;
      r_duty   <= '0;
    end else if (w_commit) begin
      case (w_addr)
        7'd0:    r_en_out[7:0]  <= w_data;
        7'd1:    r_en_out[15:8] <= w_data;
        7'd2:    r_en_pwm[7:0]  <= w_data;
        7'd3:    r_en_pwm[15:8] <= w_data;
        7'd4:    r_duty         <= w_data;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // PWM timebase
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] r_presc;
  logic [7:0]       r_pwm_cnt;
  logic             w_pwm;

  // Prescaler wraps every PWM_DIV clocks and steps the 8-bit PWM counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc   <= '0;
      r_pwm_cnt <= '0;
    end else if (r_presc == DIV_MAX) begin
      r_presc   <= '0;
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end else begin
      r_presc <= r_presc + DIV_W'(1);
    end
  end

  // Duty 0xFF is forced fully on; otherwise high while the counter is below duty.
  assign w_pwm = (r_duty == 8'hFF) || (r_pwm_cnt < r_duty);

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  logic [15:0] w_chan;
  logic [15:0] r_out;

  assign w_chan = r_en_out & (~r_en_pwm | {16{w_pwm}});

  // Registered channel outputs, optionally gated by the design-select strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out <= '0;
    end else begin
`ifdef ENA_GATE_EN
      r_out <= ena ? w_chan : '0;
`else
      r_out <= w_chan;
`endif
    end
  end

  assign uo_out  = r_out[7:0];
  assign uio_out = r_out[15:8];
  assign uio_oe  = '1;

  logic w_unused;
`ifdef ENA_GATE_EN
  assign w_unused = &{1'b0, ui_in[7:3], uio_in};
`else
  assign w_unused = &{1'b0, ena, ui_in[7:3], uio_in};
`endif

endmodule

// File: tb/tb_tt_um_uwasic_onboarding_jonathan.sv
// Self-checking bench for tt_um_uwasic_onboarding_jonathan: directed SPI
// frames, a register-file model and an expectation queue.
`timescale 1ns/1ps
module tb_tt_um_uwasic_onboarding_jonathan;

  localparam int unsigned DIV    = 13;
  localparam int unsigned PERIOD = 256 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h04;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_uwasic_onboarding_jonathan #(
    .PWM_DIV    (DIV),
    .SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #50 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [15:0] m_en_out = '0;
  logic [15:0] m_en_pwm = '0;
  logic [7:0]  m_duty   = '0;

  task automatic wait_clks(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic check_next(input logic [31:0] observed);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0h expected <entry>", observed);
    end else begin
      e = sb_q.pop_front();
      assert (observed === e.val) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, observed, e.val);
      end
    end
  endtask

  // Expected output vector for channels that are not in PWM mode.
  function automatic logic [15:0] exp_static();
    return m_en_out & ~m_en_pwm;
  endfunction

  task automatic spi_begin();
    ui_in[2] = 1'b0;
    wait_clks(4);
  endtask

  task automatic spi_shift(input logic [15:0] f, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      ui_in[1] = f[15-i];
      wait_clks(4);
      ui_in[0] = 1'b1;
      wait_clks(4);
      ui_in[0] = 1'b0;
    end
    wait_clks(4);
  endtask

  task automatic spi_end();
    ui_in[2] = 1'b1;
    wait_clks(4);
  endtask

  task automatic spi_frame(input logic rw, input logic [6:0] addr,
                           input logic [7:0] data, input int unsigned nbits);
    spi_begin();
    spi_shift({rw, addr, data}, nbits);
    spi_end();
    if (nbits == 16 && rw && addr <= 7'd4) begin
      case (addr)
        7'd0: m_en_out[7:0]  = data;
        7'd1: m_en_out[15:8] = data;
        7'd2: m_en_pwm[7:0]  = data;
        7'd3: m_en_pwm[15:8] = data;
        default: m_duty = data;
      endcase
    end
  endtask

  // Measures high time and full period of uo_out[0] in clocks (bounded waits).
  task automatic measure_pwm(output int unsigned hi, output int unsigned per);
    int unsigned n;
    int unsigned lo;
    hi = 0;
    lo = 0;
    n = 0;
    while (uo_out[0] !== 1'b0 && n < 2 * PERIOD) begin @(negedge clk); n++; end
    n = 0;
    while (uo_out[0] !== 1'b1 && n < 2 * PERIOD) begin @(negedge clk); n++; end
    while (uo_out[0] === 1'b1 && hi < 2 * PERIOD) begin @(negedge clk); hi++; end
    while (uo_out[0] !== 1'b1 && lo < 2 * PERIOD) begin @(negedge clk); lo++; end
    per = hi + lo;
  endtask

  task automatic count_level(input logic lvl, input int unsigned n,
                             output int unsigned cnt);
    cnt = 0;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      if (uo_out[0] === lvl) cnt++;
    end
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned hi;
    int unsigned per;
    int unsigned cnt;

    // Reset held for 5 clocks
    rst_n = 1'b0;
    wait_clks(5);
    rst_n = 1'b1;
    push_exp("reset_uo", 32'h00);
    push_exp("reset_uio", 32'h00);
    push_exp("reset_oe", 32'hFF);
    wait_clks(1);
    check_next({24'h0, uo_out});
    check_next({24'h0, uio_out});
    check_next({24'h0, uio_oe});

    // Static outputs
    spi_frame(1'b1, 7'h00, 8'hF0, 16);
    push_exp("static_en0", {16'h0, exp_static()});
    wait_clks(10);
    check_next({16'h0, uio_out, uo_out});
    spi_frame(1'b1, 7'h01, 8'hCC, 16);
    push_exp("static_en1", {16'h0, exp_static()});
    wait_clks(10);
    check_next({16'h0, uio_out, uo_out});

    // Dropped frames: read, out-of-range addresses, short frame
    spi_frame(1'b0, 7'h00, 8'hFF, 16);
    push_exp("read_frame", {16'h0, exp_static()});
    wait_clks(10);
    check_next({16'h0, uio_out, uo_out});
    spi_frame(1'b0, 7'h02, 8'hFF, 16);
    push_exp("read_pwm_reg", {16'h0, exp_static()});
    wait_clks(10);
    check_next({16'h0, uio_out, uo_out});
    spi_frame(1'b1, 7'h30, 8'hAA, 16);
    push_exp("addr_0x30", {16'h0, exp_static()});
    wait_clks(10);
    check_next({16'h0, uio_out, uo_out});
    spi_frame(1'b1, 7'h05, 8'h00, 16);
    push_exp("addr_0x05", {16'h0, exp_static()});
    wait_clks(10);
    check_next({16'h0, uio_out, uo_out});
    spi_frame(1'b1, 7'h01, 8'h00, 15);
    push_exp("short_frame", {16'h0, exp_static()});
    wait_clks(10);
    check_next({16'h0, uio_out, uo_out});

    // PWM 50% on channel 0
    spi_frame(1'b1, 7'h00, 8'h01, 16);
    spi_frame(1'b1, 7'h02, 8'h01, 16);
    spi_frame(1'b1, 7'h04, 8'h80, 16);
    push_exp("pwm50_uio_static", {24'h0, m_en_out[15:8]});
    push_exp("pwm50_high", 32'(128 * DIV));
    push_exp("pwm50_period", 32'(PERIOD));
    wait_clks(10);
    check_next({24'h0, uio_out});
    measure_pwm(hi, per);
    check_next(32'(hi));
    check_next(32'(per));

    // Duty extremes
    spi_frame(1'b1, 7'h04, 8'h00, 16);
    push_exp("duty00_high_clks", 32'h0);
    wait_clks(10);
    count_level(1'b1, 2 * PERIOD, cnt);
    check_next(32'(cnt));
    spi_frame(1'b1, 7'h04, 8'hFF, 16);
    push_exp("dutyFF_low_clks", 32'h0);
    wait_clks(10);
    count_level(1'b0, 2 * PERIOD, cnt);
    check_next(32'(cnt));
    spi_frame(1'b1, 7'h04, 8'h01, 16);
    push_exp("duty01_high", 32'(DIV));
    push_exp("duty01_period", 32'(PERIOD));
    wait_clks(10);
    measure_pwm(hi, per);
    check_next(32'(hi));
    check_next(32'(per));

    // Reset pulsed mid-frame aborts it
    spi_begin();
    spi_shift({1'b1, 7'h00, 8'h00}, 8);
    rst_n = 1'b0;
    wait_clks(2);
    rst_n = 1'b1;
    m_en_out = '0;
    m_en_pwm = '0;
    m_duty   = '0;
    spi_shift({8'hFF, 8'h00}, 8);
    spi_end();
    push_exp("abort_regs", {16'h0, exp_static()});
    wait_clks(10);
    check_next({16'h0, uio_out, uo_out});
    spi_frame(1'b1, 7'h00, 8'h5A, 16);
    push_exp("after_abort_write", {16'h0, exp_static()});
    wait_clks(10);
    check_next({16'h0, uio_out, uo_out});

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: observed %0d expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
